// File: rtl/eager_fork_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eager_fork_n_pkg
//  Description : Shared types for the eager fork (per-output sent state).
//  Revision    : 1.0 - initial release
// ============================================================================
package eager_fork_n_pkg;

    // Per-output token state: has this output already taken the current token
    typedef enum logic [0:0] {
        SENT_IDLE = 1'b0,
        SENT_DONE = 1'b1
    } sent_e;

endpackage : eager_fork_n_pkg
`default_nettype wire

// File: rtl/and_n.sv
`default_nettype none
// ============================================================================
//  Module      : and_n
//  Description : Support library N-input AND reduction.
//  Revision    : 1.0 - initial release
// ============================================================================
module and_n #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins,
    output logic            outs
);

    assign outs = &ins;

endmodule : and_n
`default_nettype wire

// File: rtl/eager_fork_register_block.sv
`default_nettype none
// ============================================================================
//  Module      : eager_fork_register_block
//  Description : One output lane of the eager fork: sent flag and valid gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module eager_fork_register_block
    import eager_fork_n_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    input  logic outs_ready,
    input  logic block_stop,
    output logic outs_valid,
    output logic sent
);

    sent_e r_sent;

    assign outs_valid = ins_valid && (r_sent == SENT_IDLE);
    assign sent       = (r_sent == SENT_DONE);

    // Consumption of the input token takes priority so the next token starts clean
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sent <= SENT_IDLE;
        end else if (ins_valid && !block_stop) begin
            r_sent <= SENT_IDLE;
        end else if (outs_valid && outs_ready) begin
            r_sent <= SENT_DONE;
        end
    end

endmodule : eager_fork_register_block
`default_nettype wire

// File: rtl/eager_fork_n.sv
`default_nettype none
// ============================================================================
//  Module      : eager_fork_n
//  Description : Eager 1-to-SIZE fork; each output takes each token exactly once.
//  Revision    : 1.0 - initial release
// ============================================================================
module eager_fork_n #(
    parameter int SIZE       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      ins,
    input  logic                       ins_valid,
    output logic                       ins_ready,
    output logic [SIZE*DATA_WIDTH-1:0] outs,
    output logic [SIZE-1:0]            outs_valid,
    input  logic [SIZE-1:0]            outs_ready
);

    logic [SIZE-1:0] w_sent;
    logic [SIZE-1:0] w_ready_terms;
    logic            w_block_stop;

    assign outs          = {SIZE{ins}};
    // Ready depends only on sent state and downstream ready, never on ins_valid
    assign w_ready_terms = w_sent | outs_ready;
    assign w_block_stop  = ~ins_ready;

    and_n #(
        .SIZE (SIZE)
    ) u_ready_and (
        .ins  (w_ready_terms),
        .outs (ins_ready)
    );

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
            eager_fork_register_block u_reg_block (
                .clk        (clk),
                .rst        (rst),
                .ins_valid  (ins_valid),
                .outs_ready (outs_ready[gi]),
                .block_stop (w_block_stop),
                .outs_valid (outs_valid[gi]),
                .sent       (w_sent[gi])
            );
        end
    endgenerate

endmodule : eager_fork_n
`default_nettype wire

// File: tb/tb_eager_fork_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eager_fork_n
//  Description : Self-checking bench for eager_fork_n at SIZE = 1, 2, 3 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eager_fork_n;

    logic clk;
    logic rst;

    // SIZE=3, W=8
    logic [7:0]  d3_ins;
    logic        d3_valid;
    logic        d3_ready;
    logic [23:0] d3_outs;
    logic [2:0]  d3_ov;
    logic [2:0]  d3_or;
    // SIZE=2, W=8
    logic [7:0]  d2_ins;
    logic        d2_valid;
    logic        d2_ready;
    logic [15:0] d2_outs;
    logic [1:0]  d2_ov;
    logic [1:0]  d2_or;
    // SIZE=4, W=16
    logic [15:0] d4_ins;
    logic        d4_valid;
    logic        d4_ready;
    logic [63:0] d4_outs;
    logic [3:0]  d4_ov;
    logic [3:0]  d4_or;
    // SIZE=1, W=8
    logic [7:0]  d1_ins;
    logic        d1_valid;
    logic        d1_ready;
    logic [7:0]  d1_outs;
    logic [0:0]  d1_ov;
    logic [0:0]  d1_or;

    int n_pass = 0;
    int n_chk  = 0;

    logic [15:0] q4 [4][$];
    int          rx2 [2];
    int          rx4 [4];

    eager_fork_n #(.SIZE(3), .DATA_WIDTH(8)) u_dut3 (
        .clk(clk), .rst(rst), .ins(d3_ins), .ins_valid(d3_valid), .ins_ready(d3_ready),
        .outs(d3_outs), .outs_valid(d3_ov), .outs_ready(d3_or));
    eager_fork_n #(.SIZE(2), .DATA_WIDTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .ins(d2_ins), .ins_valid(d2_valid), .ins_ready(d2_ready),
        .outs(d2_outs), .outs_valid(d2_ov), .outs_ready(d2_or));
    eager_fork_n #(.SIZE(4), .DATA_WIDTH(16)) u_dut4 (
        .clk(clk), .rst(rst), .ins(d4_ins), .ins_valid(d4_valid), .ins_ready(d4_ready),
        .outs(d4_outs), .outs_valid(d4_ov), .outs_ready(d4_or));
    eager_fork_n #(.SIZE(1), .DATA_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .ins(d1_ins), .ins_valid(d1_valid), .ins_ready(d1_ready),
        .outs(d1_outs), .outs_valid(d1_ov), .outs_ready(d1_or));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic count2();
        for (int i = 0; i < 2; i++) if (d2_ov[i] && d2_or[i]) rx2[i]++;
    endtask

    initial begin
        logic        done;
        logic [15:0] exp16;
        logic [15:0] tok;
        logic [7:0]  r8;

        rst = 1'b0;
        d3_ins = '0; d3_valid = 1'b0; d3_or = '0;
        d2_ins = '0; d2_valid = 1'b0; d2_or = '0;
        d4_ins = '0; d4_valid = 1'b0; d4_or = '0;
        d1_ins = '0; d1_valid = 1'b0; d1_or = '0;
        rx2[0] = 0; rx2[1] = 0;
        for (int i = 0; i < 4; i++) rx4[i] = 0;

        // Behaviour while held in reset
        #3;
        check("rst_ov_idle",    64'(d3_ov), 64'h0);
        check("rst_ready_none", 64'(d3_ready), 64'h0);
        d3_or = 3'b111; d3_valid = 1'b1;
        #1;
        check("rst_ready_all",  64'(d3_ready), 64'h1);
        check("rst_ov_valid",   64'(d3_ov), 64'h7);
        d3_or = 3'b000; d3_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Full broadcast in one cycle
        d3_ins = 8'hA5; d3_valid = 1'b1; d3_or = 3'b111;
        #2;
        check("bc_ready", 64'(d3_ready), 64'h1);
        check("bc_outs",  64'(d3_outs), 64'hA5A5A5);
        check("bc_ov",    64'(d3_ov), 64'h7);
        next_cycle();
        d3_valid = 1'b0; d3_or = 3'b000;
        #2;
        check("idle_ov", 64'(d3_ov), 64'h0);
        next_cycle();

        // Staggered readiness: one output per cycle
        d3_ins = 8'h3C; d3_valid = 1'b1; d3_or = 3'b001;
        #2;
        check("stg_ov0", 64'(d3_ov), 64'h7);
        check("stg_rdy0", 64'(d3_ready), 64'h0);
        next_cycle();
        d3_or = 3'b010;
        #2;
        check("stg_ov1", 64'(d3_ov), 64'h6);
        check("stg_rdy1", 64'(d3_ready), 64'h0);
        next_cycle();
        d3_or = 3'b100;
        #2;
        check("stg_ov2", 64'(d3_ov), 64'h4);
        check("stg_rdy2", 64'(d3_ready), 64'h1);
        next_cycle();
        d3_valid = 1'b0; d3_or = 3'b000;
        next_cycle();

        // Reset mid-token discards partial-send history
        d3_ins = 8'h5A; d3_valid = 1'b1; d3_or = 3'b011;
        #2;
        check("mr_rdy", 64'(d3_ready), 64'h0);
        next_cycle();
        d3_or = 3'b000;
        #2;
        check("mr_ov_partial", 64'(d3_ov), 64'h4);
        rst = 1'b0;
        #1;
        check("mr_ov_in_rst", 64'(d3_ov), 64'h7);
        rst = 1'b1;
        next_cycle();
        check("mr_ov_after", 64'(d3_ov), 64'h7);
        d3_or = 3'b111;
        #2;
        check("mr_rdy_final", 64'(d3_ready), 64'h1);
        next_cycle();
        d3_valid = 1'b0; d3_or = 3'b000;

        // SIZE=2: one output stalls while the other is ready for three cycles
        d2_ins = 8'h77; d2_valid = 1'b1; d2_or = 2'b01;
        #2;
        check("s2_ov_c1", 64'(d2_ov), 64'h3);
        check("s2_rdy_c1", 64'(d2_ready), 64'h0);
        count2();
        next_cycle();
        for (int c = 2; c <= 3; c++) begin
            #1;
            check($sformatf("s2_ov_c%0d", c), 64'(d2_ov), 64'h2);
            check($sformatf("s2_rdy_c%0d", c), 64'(d2_ready), 64'h0);
            count2();
            next_cycle();
        end
        d2_or = 2'b11;
        #2;
        check("s2_ov_c4", 64'(d2_ov), 64'h2);
        check("s2_rdy_c4", 64'(d2_ready), 64'h1);
        count2();
        next_cycle();
        d2_valid = 1'b0; d2_or = 2'b00;
        check("s2_rx0", 64'(rx2[0]), 64'd1);
        check("s2_rx1", 64'(rx2[1]), 64'd1);

        // SIZE=4: back-to-back tokens with random downstream readiness
        for (int t = 1; t <= 16; t++) begin
            tok = t[15:0];
            d4_ins = tok; d4_valid = 1'b1;
            for (int i = 0; i < 4; i++) q4[i].push_back(tok);
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                d4_or = 4'($urandom);
                #2;
                for (int i = 0; i < 4; i++) begin
                    if (d4_ov[i] && d4_or[i]) begin
                        rx4[i]++;
                        if (q4[i].size() == 0) begin
                            check($sformatf("s4_dup%0d", i), 64'h1, 64'h0);
                        end else begin
                            exp16 = q4[i].pop_front();
                            check($sformatf("s4_out%0d", i), 64'(d4_outs[i*16 +: 16]), 64'(exp16));
                        end
                    end
                end
                done = d4_ready;
                next_cycle();
            end
            if (!done) check("s4_timeout", 64'h0, 64'h1);
        end
        d4_valid = 1'b0; d4_or = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s4_left%0d", i), 64'(q4[i].size()), 64'd0);
            check($sformatf("s4_rx%0d", i), 64'(rx4[i]), 64'd16);
        end

        // SIZE=1: pure wire
        for (int c = 0; c < 30; c++) begin
            r8 = 8'($urandom);
            d1_ins = r8;
            d1_valid = 1'($urandom);
            d1_or = 1'($urandom);
            #2;
            check("s1_outs", 64'(d1_outs), 64'(r8));
            check("s1_ov", 64'(d1_ov), 64'(d1_valid));
            check("s1_rdy", 64'(d1_ready), 64'(d1_or));
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_eager_fork_n
`default_nettype wire
